// File: rtl/conv_stream_accum.sv
`default_nettype none
// ============================================================================
// Module      : conv_stream_accum
// Description : Streaming KxK convolution engine. Loads one kernel per
//               (kernel, channel) pair, slides it over an IWxIH map received
//               two columns per beat, accumulates channel partial sums into
//               an on-chip result map and drains each finished map two words
//               per beat under valid/ready back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_stream_accum #(
    parameter int DW      = 8,
    parameter int AW      = 25,
    parameter int K       = 4,
    parameter int IW      = 64,
    parameter int IH      = 64,
    parameter int CH_STEP = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start_conv,
    input  logic [2:0]            in_cfg_ci,
    input  logic [2:0]            in_cfg_co,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*K*DW-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_data0,
    output logic [AW-1:0]         out_data1,
    output logic                  out_data1_vld,
    output logic                  out_last,
    output logic                  out_end_conv
);

    localparam int LANES  = 2*K;
    localparam int OW     = IW-K+1;
    localparam int OH     = IH-K+1;
    localparam int DEPTH  = OW*OH;
    localparam int HALF_K = K/2;
    localparam int BEATS  = IW/2;
    localparam int MDW    = $clog2(DEPTH);
    localparam int ADW    = $clog2(DEPTH+2);
    localparam int BW     = $clog2(BEATS);
    localparam int RW     = $clog2(OH+1);
    localparam int CW     = $clog2(8*CH_STEP);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_load_k = 3'd1;
    localparam logic [2:0] c_fill   = 3'd2;
    localparam logic [2:0] c_stream = 3'd3;
    localparam logic [2:0] c_drain  = 3'd4;
    localparam logic [2:0] c_done   = 3'd5;

    logic [2:0]     r_state;
    logic [2:0]     w_next_state;
    logic [BW-1:0]  r_beat;
    logic [RW-1:0]  r_row;
    logic [MDW-1:0] r_row_base;
    logic [CW-1:0]  r_chan;
    logic [CW-1:0]  r_kern;
    logic [CW-1:0]  r_last_ch;
    logic [CW-1:0]  r_last_k;
    logic [ADW-1:0] r_addr;

    logic [DW-1:0]  r_kernel [K][K];     // [tap row][tap col]
    logic [DW-1:0]  r_win    [K-1][K];   // last K-1 input columns, oldest first
    logic [AW-1:0]  r_mem    [2**MDW];

    logic [DW-1:0]  w_lane   [LANES];
    logic [DW-1:0]  w_ext    [K+1][K];   // stored columns followed by the two new ones
    logic [AW-1:0]  w_sum_a;
    logic [AW-1:0]  w_sum_b;
    logic [MDW-1:0] w_addr_a;
    logic [MDW-1:0] w_addr_b;
    logic [ADW-1:0] w_addr1;
    logic           w_accept;
    logic           w_out_hs;
    logic           w_half_last;
    logic           w_row_end;
    logic           w_last_row;
    logic           w_last_ch;
    logic           w_last_k;
    logic           w_wr_a;
    logic           w_wr_b;
    logic           w_start;

    assign in_ready     = (r_state == c_load_k) || (r_state == c_fill) || (r_state == c_stream);
    assign out_valid    = (r_state == c_drain);
    assign out_end_conv = (r_state == c_done);

    assign w_accept    = in_valid && in_ready;
    assign w_out_hs    = out_valid && out_ready;
    assign w_start     = in_start_conv && ((r_state == c_idle) || (r_state == c_done));
    assign w_half_last = (r_beat == BW'(HALF_K-1));
    assign w_row_end   = (r_beat == BW'(BEATS-1));
    assign w_last_row  = (r_row == RW'(OH-1));
    assign w_last_ch   = (r_chan == r_last_ch);
    assign w_last_k    = (r_kern == r_last_k);

    // Stream beat m yields columns 2m+1 (a) and 2m+2 (b); the last fill beat yields column 0 via b.
    assign w_addr_b = r_row_base + MDW'({r_beat, 1'b0}) + MDW'(2) - MDW'(K);
    assign w_addr_a = w_addr_b - MDW'(1);
    assign w_wr_a   = w_accept && (r_state == c_stream);
    assign w_wr_b   = w_accept && ((r_state == c_stream) || ((r_state == c_fill) && w_half_last));

    // Drain outputs read straight from the result map, which is frozen while draining.
    assign w_addr1       = r_addr + ADW'(1);
    assign out_data1_vld = out_valid && (w_addr1 < ADW'(DEPTH));
    assign out_last      = out_valid && ((r_addr + ADW'(2)) >= ADW'(DEPTH));
    assign out_data0     = out_valid ? r_mem[r_addr[MDW-1:0]] : '0;
    assign out_data1     = out_data1_vld ? r_mem[w_addr1[MDW-1:0]] : '0;

    // Unpack lanes, assemble the extended window and form both window sums.
    always_comb begin
        w_sum_a = '0;
        w_sum_b = '0;
        for (int j = 0; j < LANES; j++) begin
            w_lane[j] = in_data[j*DW +: DW];
        end
        for (int c = 0; c < K-1; c++) begin
            for (int y = 0; y < K; y++) begin
                w_ext[c][y] = r_win[c][y];
            end
        end
        for (int y = 0; y < K; y++) begin
            w_ext[K-1][y] = w_lane[y];
            w_ext[K][y]   = w_lane[K+y];
        end
        for (int y = 0; y < K; y++) begin
            for (int x = 0; x < K; x++) begin
                w_sum_a = w_sum_a + AW'({{DW{1'b0}}, w_ext[x][y]}   * {{DW{1'b0}}, r_kernel[y][x]});
                w_sum_b = w_sum_b + AW'({{DW{1'b0}}, w_ext[x+1][y]} * {{DW{1'b0}}, r_kernel[y][x]});
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle, c_done: if (w_start) w_next_state = c_load_k;
            c_load_k:       if (w_accept && w_half_last) w_next_state = c_fill;
            c_fill:         if (w_accept && w_half_last) w_next_state = c_stream;
            c_stream: begin
                if (w_accept && w_row_end) begin
                    if (!w_last_row)    w_next_state = c_fill;
                    else if (w_last_ch) w_next_state = c_drain;
                    else                w_next_state = c_load_k;
                end
            end
            c_drain:        if (w_out_hs && out_last) w_next_state = w_last_k ? c_done : c_load_k;
            default:        w_next_state = c_idle;
        endcase
    end

    // Job, channel, row, beat and drain-address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_chan     <= '0;
            r_kern     <= '0;
            r_last_ch  <= '0;
            r_last_k   <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (w_start) begin
                        r_last_ch  <= CW'((int'(in_cfg_ci) + 1) * CH_STEP - 1);
                        r_last_k   <= CW'((int'(in_cfg_co) + 1) * CH_STEP - 1);
                        r_beat     <= '0;
                        r_row      <= '0;
                        r_row_base <= '0;
                        r_chan     <= '0;
                        r_kern     <= '0;
                        r_addr     <= '0;
                    end
                end
                c_load_k: if (w_accept) r_beat <= w_half_last ? '0 : r_beat + BW'(1);
                c_fill:   if (w_accept) r_beat <= r_beat + BW'(1);
                c_stream: begin
                    if (w_accept) begin
                        if (w_row_end) begin
                            r_beat <= '0;
                            if (w_last_row) begin
                                r_row      <= '0;
                                r_row_base <= '0;
                                r_chan     <= w_last_ch ? '0 : r_chan + CW'(1);
                            end else begin
                                r_row      <= r_row + RW'(1);
                                r_row_base <= r_row_base + MDW'(OW);
                            end
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                c_drain: begin
                    if (w_out_hs) begin
                        if (out_last) begin
                            r_addr <= '0;
                            r_kern <= w_last_k ? '0 : r_kern + CW'(1);
                        end else begin
                            r_addr <= r_addr + ADW'(2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Kernel load, window shift and result-map accumulation (no reset: contents are rewritten before use).
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == c_load_k)) begin
            for (int b = 0; b < HALF_K; b++) begin
                if (r_beat == BW'(b)) begin
                    for (int j = 0; j < LANES; j++) begin
                        r_kernel[2*b + j/K][j%K] <= w_lane[j];
                    end
                end
            end
        end
        if (w_accept && ((r_state == c_fill) || (r_state == c_stream))) begin
            for (int c = 0; c < K-1; c++) begin
                for (int y = 0; y < K; y++) begin
                    r_win[c][y] <= w_ext[c+2][y];
                end
            end
        end
        if (w_wr_a) r_mem[w_addr_a] <= (r_chan == '0) ? w_sum_a : r_mem[w_addr_a] + w_sum_a;
        if (w_wr_b) r_mem[w_addr_b] <= (r_chan == '0) ? w_sum_b : r_mem[w_addr_b] + w_sum_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_stream_accum
// Description : Self-checking bench for conv_stream_accum (K=4, 8x8 map)
//               against a direct-convolution reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_stream_accum;

    localparam int DW = 8, AW = 25, K = 4, IW = 8, IH = 8, CH_STEP = 8;
    localparam int LANES = 2*K, OW = IW-K+1, OH = IH-K+1, DEPTH = OW*OH;
    localparam int BPP = K/2 + OH*(IW/2);   // input beats per (kernel, channel)

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_start_conv;
    logic [2:0]           in_cfg_ci;
    logic [2:0]           in_cfg_co;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*DW-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_data0;
    logic [AW-1:0]        out_data1;
    logic                 out_data1_vld;
    logic                 out_last;
    logic                 out_end_conv;

    always #5 clk = ~clk;

    conv_stream_accum #(.DW(DW), .AW(AW), .K(K), .IW(IW), .IH(IH), .CH_STEP(CH_STEP)) dut (
        .clk(clk), .rst(rst), .in_start_conv(in_start_conv),
        .in_cfg_ci(in_cfg_ci), .in_cfg_co(in_cfg_co),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data1_vld(out_data1_vld), .out_last(out_last),
        .out_end_conv(out_end_conv)
    );

    typedef struct packed {
        logic [AW-1:0] d0;
        logic [AW-1:0] d1;
        logic          v1;
        logic          last;
    } exp_t;

    int                  n_vec = 0;
    int                  n_err = 0;
    int unsigned         kern [64][64][K][K];   // [kernel][channel][row][col]
    int unsigned         inp  [64][IH][IW];     // [channel][y][x]
    logic [LANES*DW-1:0] beats [$];
    exp_t                expq  [$];

    // Fill operands, build the input beat stream and the expected drain beats.
    task automatic prep(input int mode, input int nk, input int nc);
        logic [LANES*DW-1:0] w;
        logic [AW-1:0]       res [DEPTH];
        longint              s;
        exp_t                e;
        for (int k = 0; k < nk; k++)
            for (int c = 0; c < nc; c++)
                for (int y = 0; y < K; y++)
                    for (int x = 0; x < K; x++)
                        case (mode)
                            0:       kern[k][c][y][x] = 1;
                            1:       kern[k][c][y][x] = (y == 0 && x == 0) ? 1 : 0;
                            2:       kern[k][c][y][x] = 255;
                            default: kern[k][c][y][x] = $urandom_range(255);
                        endcase
        for (int c = 0; c < nc; c++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++)
                    case (mode)
                        0:       inp[c][y][x] = 1;
                        1:       inp[c][y][x] = y*8 + x;
                        2:       inp[c][y][x] = 255;
                        default: inp[c][y][x] = $urandom_range(255);
                    endcase
        beats.delete();
        expq.delete();
        for (int k = 0; k < nk; k++) begin
            for (int c = 0; c < nc; c++) begin
                for (int b = 0; b < K/2; b++) begin
                    w = '0;
                    for (int j = 0; j < LANES; j++) w[j*DW +: DW] = DW'(kern[k][c][2*b + j/K][j%K]);
                    beats.push_back(w);
                end
                for (int r = 0; r < OH; r++) begin
                    for (int b = 0; b < IW/2; b++) begin
                        w = '0;
                        for (int j = 0; j < LANES; j++) w[j*DW +: DW] = DW'(inp[c][r + j%K][2*b + j/K]);
                        beats.push_back(w);
                    end
                end
            end
            for (int a = 0; a < DEPTH; a++) begin
                s = 0;
                for (int c = 0; c < nc; c++)
                    for (int y = 0; y < K; y++)
                        for (int x = 0; x < K; x++)
                            s += longint'(kern[k][c][y][x] * inp[c][a/OW + y][a%OW + x]);
                res[a] = AW'(s);
            end
            for (int a = 0; a < DEPTH; a += 2) begin
                e.d0   = res[a];
                e.v1   = (a + 1 < DEPTH);
                e.d1   = e.v1 ? res[a+1] : '0;
                e.last = (a + 2 >= DEPTH);
                expq.push_back(e);
            end
        end
    endtask

    // Start a job, stream it with optional bubbles/back-pressure and check every drain beat.
    task automatic run_job(input int mode, input int ci, input int co, input int bubble,
                           input int rmode, input int abort_at, input int start_at, input string name);
        int   nc = (ci + 1) * CH_STEP;
        int   nk = (co + 1) * CH_STEP;
        int   ip = 0, op = 0, cyc = 0, limit;
        bit   want_valid = 0, want_ready = 0;
        exp_t e;
        prep(mode, nk, nc);
        limit = beats.size()*4 + expq.size()*8 + 200;
        in_cfg_ci = 3'(ci);
        in_cfg_co = 3'(co);
        in_start_conv = 1'b1;
        @(negedge clk);
        in_start_conv = 1'b0;
        in_cfg_ci = 3'($urandom);
        in_cfg_co = 3'($urandom);
        n_vec++;
        if (in_ready !== 1'b1 || out_end_conv !== 1'b0) begin
            n_err++;
            $display("FAIL %s start: in_ready=%b out_end_conv=%b, want 1 0", name, in_ready, out_end_conv);
        end
        while ((ip < beats.size() || op < expq.size()) && cyc < limit) begin
            if (want_valid) begin
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s drain latency: out_valid=%b, want 1", name, out_valid);
                end
                want_valid = 0;
            end
            if (want_ready) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s next kernel: in_ready=%b, want 1", name, in_ready);
                end
                want_ready = 0;
            end
            if (abort_at >= 0 && ip == abort_at) break;
            in_start_conv = (start_at >= 0 && ip == start_at);
            in_valid = (ip < beats.size()) && ($urandom_range(99) >= bubble);
            in_data  = (ip < beats.size()) ? beats[ip] : '0;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(1));
            endcase
            if (out_valid === 1'b1) begin
                n_vec++;
                if (op >= expq.size()) begin
                    n_err++;
                    $display("FAIL %s extra output beat: d0=%0d", name, out_data0);
                end else begin
                    e = expq[op];
                    if ({out_data0, out_data1, out_data1_vld, out_last} !== e) begin
                        n_err++;
                        $display("FAIL %s beat %0d: got d0=%0d d1=%0d v1=%b last=%b, want d0=%0d d1=%0d v1=%b last=%b",
                                 name, op, out_data0, out_data1, out_data1_vld, out_last, e.d0, e.d1, e.v1, e.last);
                    end
                    if (out_ready) begin
                        if (e.last && (op + 1 < expq.size())) want_ready = 1;
                        op++;
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                if ((ip + 1) % (nc * BPP) == 0) want_valid = 1;
                ip++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        in_start_conv = 1'b0;
        out_ready = 1'b0;
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_end_conv !== 1'b0) begin
                n_err++;
                $display("FAIL %s abort: in_ready=%b out_valid=%b end=%b, want 0 0 0", name, in_ready, out_valid, out_end_conv);
            end
            return;
        end
        n_vec++;
        if (cyc >= limit) begin
            n_err++;
            $display("FAIL %s timeout: %0d/%0d beats in, %0d/%0d beats out", name, ip, beats.size(), op, expq.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_end_conv !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s done: end=%b in_ready=%b out_valid=%b, want 1 0 0", name, out_end_conv, in_ready, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready      !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_vec++; if (out_valid     !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data0     !== '0)   begin n_err++; $display("FAIL reset out_data0: got %0d want 0", out_data0); end
        n_vec++; if (out_data1     !== '0)   begin n_err++; $display("FAIL reset out_data1: got %0d want 0", out_data1); end
        n_vec++; if (out_data1_vld !== 1'b0) begin n_err++; $display("FAIL reset out_data1_vld: got %b want 0", out_data1_vld); end
        n_vec++; if (out_last      !== 1'b0) begin n_err++; $display("FAIL reset out_last: got %b want 0", out_last); end
        n_vec++; if (out_end_conv  !== 1'b0) begin n_err++; $display("FAIL reset out_end_conv: got %b want 0", out_end_conv); end
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_all_ones();
        run_job(0, 0, 0, 0, 0, -1, -1, "ones");
    endtask

    task automatic test_impulse();
        run_job(1, 0, 0, 0, 0, -1, -1, "impulse");
    endtask

    task automatic test_backpressure();
        run_job(0, 0, 0, 30, 1, -1, -1, "backpressure");
    endtask

    task automatic test_reset_mid();
        run_job(3, 0, 0, 20, 0, 12, -1, "abort");
        run_job(0, 0, 0, 0, 0, -1, -1, "after_abort");
    endtask

    task automatic test_start_ignored();
        run_job(3, 0, 0, 25, 0, -1, 12, "start_in_stream");
    endtask

    task automatic test_restart_from_done();
        run_job(3, 1, 0, 10, 2, -1, -1, "restart");
    endtask

    task automatic test_random();
        run_job(3, int'($urandom_range(1)), int'($urandom_range(1)), 20, 2, -1, -1, "random");
    endtask

    task automatic test_wrap();
        run_job(2, 7, 0, 0, 0, -1, -1, "wrap");
    endtask

    initial begin
        rst = 1'b1;
        in_start_conv = 1'b0;
        in_cfg_ci = '0;
        in_cfg_co = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_impulse();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_restart_from_done();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
